// File: rtl/ahb_master_arbiter.sv
// Round-robin AHB master arbiter: muxes NO_OF_MASTERS requesters onto one bridge slave port.
// Latency: bus mux is combinational; grant moves one HCLK after an arbitration point.
// Backpressure: HREADY=0 freezes grant, data-phase owner and transfer count.
module ahb_master_arbiter #(
  parameter int NO_OF_MASTERS = 4,
  parameter int ADDR_WIDTH    = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int BURST_LIMIT   = 16,
  localparam int MW = (NO_OF_MASTERS > 1) ? $clog2(NO_OF_MASTERS) : 1,
  localparam int CW = $clog2(BURST_LIMIT) + 1
) (
  input  logic                                HCLK,
  input  logic                                HRESET,
  input  logic [NO_OF_MASTERS-1:0]            HBUSREQ,
  input  logic [NO_OF_MASTERS*ADDR_WIDTH-1:0] HADDR_M,
  input  logic [NO_OF_MASTERS*2-1:0]          HTRANS_M,
  input  logic [NO_OF_MASTERS-1:0]            HWRITE_M,
  input  logic [NO_OF_MASTERS*DATA_WIDTH-1:0] HWDATA_M,
  input  logic                                HREADY,
  input  logic                                HRESP,
  output logic [ADDR_WIDTH-1:0]               HADDR,
  output logic [1:0]                          HTRANS,
  output logic                                HWRITE,
  output logic [DATA_WIDTH-1:0]               HWDATA,
  output logic                                HSELAHB,
  output logic [NO_OF_MASTERS-1:0]            HGRANT,
  output logic [MW-1:0]                       HMASTER,
  output logic [MW-1:0]                       HMASTER_DATA,
  output logic [NO_OF_MASTERS-1:0]            HRESP_M
);

  localparam logic [1:0] ST_PARK     = 2'd0;
  localparam logic [1:0] ST_OWNED    = 2'd1;
  localparam logic [1:0] ST_HANDOVER = 2'd2;

  localparam logic [1:0] TR_IDLE   = 2'b00;
  localparam logic [1:0] TR_NONSEQ = 2'b10;

  logic [1:0]               state;
  logic [CW-1:0]            xfer_cnt;
  logic                     limit_hit;
  logic                     others_req;
  logic                     owner_req;
  logic                     any_req;
  logic                     arb_point;
  logic                     xfer_acc;
  logic                     grant_chg;
  logic [NO_OF_MASTERS-1:0] req_eff;
  logic [MW-1:0]            winner;
  logic [MW-1:0]            cand;
  logic                     found;

  // Address/control come from the address-phase owner, write data from the data-phase owner.
  assign HADDR   = HADDR_M[HMASTER*ADDR_WIDTH +: ADDR_WIDTH];
  assign HTRANS  = HTRANS_M[HMASTER*2 +: 2];
  assign HWRITE  = HWRITE_M[HMASTER];
  assign HWDATA  = HWDATA_M[HMASTER_DATA*DATA_WIDTH +: DATA_WIDTH];
  assign HSELAHB = HTRANS[1];

  assign xfer_acc   = HREADY && HTRANS[1];
  assign others_req = |(HBUSREQ & ~HGRANT);
  assign limit_hit  = (xfer_cnt == CW'(BURST_LIMIT));

  // Once the owner has used its transfer budget, hide its request while anyone else is waiting.
  always_comb begin
    req_eff = HBUSREQ;
    if (limit_hit && others_req) begin
      req_eff[HMASTER] = 1'b0;
    end
  end

  assign owner_req = req_eff[HMASTER];
  assign any_req   = |req_eff;

  // Grant may only move between transfers: owner idle, or owner starting a NONSEQ it no longer wants to keep.
  assign arb_point = HREADY && ((HTRANS == TR_IDLE) || ((HTRANS == TR_NONSEQ) && !owner_req));

  // Round-robin search from HMASTER+1, wrapping, with the current owner considered last.
  always_comb begin
    winner = HMASTER;
    found  = 1'b0;
    cand   = '0;
    for (int k = 1; k <= NO_OF_MASTERS; k++) begin
      cand = MW'((int'(HMASTER) + k) % NO_OF_MASTERS);
      if (!found && req_eff[cand]) begin
        winner = cand;
        found  = 1'b1;
      end
    end
  end

  assign grant_chg = arb_point && any_req && (winner != HMASTER);

  // Grant register and arbitration state; grant is only touched at an arbitration point.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      HGRANT  <= NO_OF_MASTERS'(1);
      HMASTER <= '0;
      state   <= ST_PARK;
    end else if (arb_point) begin
      if (!any_req) begin
        state <= ST_PARK;
      end else if (winner != HMASTER) begin
        HGRANT  <= NO_OF_MASTERS'(1) << winner;
        HMASTER <= winner;
        state   <= ST_HANDOVER;
      end else begin
        state <= ST_OWNED;
      end
    end else if (state == ST_HANDOVER) begin
      state <= ST_OWNED;
    end
  end

  // Transfers accepted for the current owner; restarts on handover and sticks at the limit.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      xfer_cnt <= '0;
    end else if (grant_chg) begin
      xfer_cnt <= '0;
    end else if (xfer_acc && !limit_hit) begin
      xfer_cnt <= xfer_cnt + 1'b1;
    end
  end

  // Data-phase owner follows the address phase each time a real transfer is accepted.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      HMASTER_DATA <= '0;
    end else if (xfer_acc) begin
      HMASTER_DATA <= HMASTER;
    end
  end

  // Route the bridge response back only to the master owning the data phase.
  always_comb begin
    HRESP_M = '0;
    if (!HRESET) begin
      HRESP_M[HMASTER_DATA] = HRESP;
    end
  end

endmodule

// File: doc/ahb_master_arbiter.md
AHB_MASTER_ARBITER -- requirements
Module: ahb_master_arbiter

Interface
REQ-001 SHALL have parameter NO_OF_MASTERS, default 4, number of AHB requesters sharing one bridge slave port.
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, address width.
REQ-003 SHALL have parameter DATA_WIDTH, default 32, data width.
REQ-004 SHALL have parameter BURST_LIMIT, default 16, the transfer count after which the owner loses priority.
REQ-005 SHALL have HCLK, input, 1, the single clock; all logic is on posedge HCLK.
REQ-006 SHALL have HRESET, input, 1, a synchronous, active-high reset.
REQ-007 SHALL have HBUSREQ, input, NO_OF_MASTERS, per-master bus request.
REQ-008 SHALL have HADDR_M, input, NO_OF_MASTERS*ADDR_WIDTH, packed per-master address; master i occupies slice i.
REQ-009 SHALL have HTRANS_M, input, NO_OF_MASTERS*2, packed per-master transfer type (IDLE=00, BUSY=01, NONSEQ=10, SEQ=11).
REQ-010 SHALL have HWRITE_M, input, NO_OF_MASTERS, per-master write flag.
REQ-011 SHALL have HWDATA_M, input, NO_OF_MASTERS*DATA_WIDTH, packed per-master write data.
REQ-012 SHALL have HREADY and HRESP, inputs, 1 each, driven by the bridge.
REQ-013 SHALL have HADDR, HTRANS, HWRITE and HWDATA, outputs, bus widths, the muxed bridge-side AHB signals.
REQ-014 SHALL have HSELAHB, output, 1, the bridge select.
REQ-015 SHALL have HGRANT, output, NO_OF_MASTERS, one-hot grant.
REQ-016 SHALL have HMASTER, output, clog2(NO_OF_MASTERS), the address-phase owner index.
REQ-017 SHALL have HMASTER_DATA, output, clog2(NO_OF_MASTERS), the data-phase owner index.
REQ-018 SHALL have HRESP_M, output, NO_OF_MASTERS, per-master routed error response.

Function
REQ-019 SHALL drive HADDR/HTRANS/HWRITE combinationally from slice HMASTER, and HWDATA from slice HMASTER_DATA.
REQ-020 SHALL set HSELAHB = HTRANS[1], asserted only for NONSEQ or SEQ.
REQ-021 SHALL implement FSM states: PARK (no requester; grant held by last owner, HTRANS of owner forwarded), OWNED (owner mid-sequence), HANDOVER (one cycle; new HGRANT/HMASTER registered).
REQ-022 SHALL define an arbitration point as a cycle with HREADY=1 and owner HTRANS=IDLE, or HREADY=1 and owner HTRANS=NONSEQ with owner HBUSREQ=0.
REQ-023 SHALL never change grant while owner HTRANS is SEQ or BUSY, or while HREADY=0.
REQ-024 SHALL grant, at an arbitration point, the first requester in round-robin order starting at HMASTER+1 and wrapping past NO_OF_MASTERS-1 to 0; the owner is included last in that order.
REQ-025 SHALL register the new HGRANT/HMASTER at the clock edge ending the arbitration-point cycle, so the new owner drives its address phase in the next cycle (1-cycle grant latency).
REQ-026 SHALL stay in, or return to, PARK with unchanged grant when no HBUSREQ is set at an arbitration point.
REQ-027 SHALL update HMASTER_DATA <= HMASTER on each edge where HREADY=1 and HTRANS[1]=1, and hold it otherwise.
REQ-028 SHALL set HRESP_M[HMASTER_DATA] = HRESP, with all other bits 0.
REQ-029 SHALL keep a transfer counter (width clog2(BURST_LIMIT)+1) that increments on each accepted NONSEQ/SEQ, clears on grant change, and saturates at BURST_LIMIT.
REQ-030 SHALL, when the counter equals BURST_LIMIT, treat the owner's HBUSREQ as 0 at the next arbitration point if any other HBUSREQ is set.
REQ-031 SHALL keep the owner when the counter equals BURST_LIMIT and no other HBUSREQ is set; the counter stays saturated.
REQ-032 SHALL, when HRESP=1 with HREADY=0, hold the grant and keep HMASTER_DATA unchanged.

Reset
REQ-033 SHALL, while HRESET=1 at a posedge, set HGRANT=0001, HMASTER=0, HMASTER_DATA=0, counter=0, state=PARK.
REQ-034 SHALL hold HRESP_M=0 while HRESET=1.
REQ-035 SHALL, on reset asserted mid-burst, take effect at the next edge and discard the burst without completing it.
REQ-036 SHALL sample requests on the first edge after HRESET deasserts.

Verification
REQ-037 SHALL cover: reset, then HBUSREQ=0000 -> HGRANT=0001, HMASTER=0, HSELAHB=0.
REQ-038 SHALL cover: masters 1 and 3 request with owner 0 issuing IDLE and HREADY=1 -> next cycle HMASTER=1; at the next arbitration point -> HMASTER=3.
REQ-039 SHALL cover: owner 2 in a 4-beat INCR (NONSEQ,SEQ,SEQ,SEQ), master 0 requesting -> grant stays 2 through the last SEQ and moves to 0 only after owner IDLE.
REQ-040 SHALL cover: HREADY=0 for 3 cycles during owner 1's data phase -> HMASTER_DATA=1 held, HWDATA=slice 1, grant unchanged.
REQ-041 SHALL cover: owner 0 reaches 16 transfers while master 2 requests -> grant to 2 at the next arbitration point; master 2 alone with limit reached -> retains grant.
REQ-042 SHALL cover: HRESP=1 during master 3's data phase -> HRESP_M=1000.
